// File: rtl/multi_channel_scheduler_if.sv
// multi_channel_scheduler_if: request-port handshakes and command-FIFO head of the scheduler.
interface multi_channel_scheduler_if #(
   parameter int CHANNELS   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   logic [CHANNELS-1:0]            ch_req_valid;
   logic [CHANNELS-1:0]            ch_req_ready;
   logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr_packed;
   logic [CHANNELS*DATA_WIDTH-1:0] ch_wdata_packed;
   logic [CHANNELS-1:0]            ch_wr_en;
   logic                           cmd_valid;
   logic                           cmd_ready;
   logic [ADDR_WIDTH-1:0]          cmd_addr;
   logic [DATA_WIDTH-1:0]          cmd_wdata;
   logic                           cmd_wr;
   logic                           cmd_refresh;
   logic [$clog2(CHANNELS)-1:0]    cmd_ch;
   modport master (
      input  ch_req_valid, ch_addr_packed, ch_wdata_packed, ch_wr_en, cmd_ready,
      output ch_req_ready, cmd_valid, cmd_addr, cmd_wdata, cmd_wr, cmd_refresh, cmd_ch
   );
   modport slave (
      output ch_req_valid, ch_addr_packed, ch_wdata_packed, ch_wr_en, cmd_ready,
      input  ch_req_ready, cmd_valid, cmd_addr, cmd_wdata, cmd_wr, cmd_refresh, cmd_ch
   );
endinterface

// File: rtl/multi_channel_scheduler.sv
// multi_channel_scheduler: arbitrates request ports (round robin, fixed, credit-weighted)
// into a fall-through command FIFO, inserting periodic refresh commands.
module multi_channel_scheduler #(
   parameter int CHANNELS     = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int QUEUE_DEPTH  = 8,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic [1:0]                         arb_mode,
   input  logic [31:0]                        refresh_interval,
   input  logic [CHANNELS*WEIGHT_WIDTH-1:0]   ch_weight_packed,
   multi_channel_scheduler_if.master          bus,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
   output logic                               ready,
   output logic [1:0]                         error_status
);
   localparam int CW = $clog2(CHANNELS);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int QW = $clog2(QUEUE_DEPTH+1);

   typedef struct packed {
      logic                  refresh;
      logic                  wr;
      logic [CW-1:0]         ch;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } entry_t;

   logic [WEIGHT_WIDTH-1:0] weight [CHANNELS];
   logic [ADDR_WIDTH-1:0]   addr_arr [CHANNELS];
   logic [DATA_WIDTH-1:0]   wdata_arr [CHANNELS];
   logic [WEIGHT_WIDTH-1:0] credit, limit;
   logic [CW-1:0]           ptr, start, gnt_idx, idx;
   logic [1:0]              mode_q;
   logic [31:0]             refresh_cnt;
   logic [PW-1:0]           wptr, rptr;
   logic                    hold, gnt_any, grant_ok, xfer, full, rpush, push, pop, pending, deadline;
   entry_t                  mem [QUEUE_DEPTH];
   entry_t                  push_entry, head;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
      assign weight[i]    = ch_weight_packed[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign addr_arr[i]  = bus.ch_addr_packed[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = bus.ch_wdata_packed[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // a zero weight still earns one grant per turn
   assign limit = weight[ptr] == '0 ? WEIGHT_WIDTH'(1) : weight[ptr];

   always_comb begin
      hold    = arb_mode == 2'b10 && credit != '0 && credit < limit && bus.ch_req_valid[ptr];
      start   = arb_mode == 2'b01 ? '0 : hold ? ptr : ptr == CW'(CHANNELS-1) ? '0 : ptr + 1'b1;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = CW'((int'(start) + i) % CHANNELS);
         if (!gnt_any && bus.ch_req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign full             = queue_count == QW'(QUEUE_DEPTH);
   assign grant_ok         = enable && !full && !pending && arb_mode != 2'b11;
   assign xfer             = grant_ok && gnt_any;
   assign bus.ch_req_ready = xfer ? CHANNELS'(1) << gnt_idx : '0;
   assign rpush            = pending && !full;
   assign push             = xfer || rpush;
   assign pop              = bus.cmd_valid && bus.cmd_ready;
   assign deadline         = enable && refresh_interval != '0 && refresh_cnt >= refresh_interval - 32'd1;
   assign ready            = enable && queue_count == '0 && !pending;

   always_comb begin
      push_entry         = '0;
      push_entry.refresh = rpush;
      push_entry.wr      = !rpush && bus.ch_wr_en[gnt_idx];
      push_entry.ch      = rpush ? '0 : gnt_idx;
      push_entry.addr    = rpush ? '0 : addr_arr[gnt_idx];
      push_entry.wdata   = rpush ? '0 : wdata_arr[gnt_idx];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_entry;
   end

   assign head            = mem[rptr];
   assign bus.cmd_valid   = queue_count != '0;
   assign bus.cmd_addr    = head.addr;
   assign bus.cmd_wdata   = head.wdata;
   assign bus.cmd_wr      = head.wr;
   assign bus.cmd_refresh = head.refresh;
   assign bus.cmd_ch      = head.ch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr          <= CW'(CHANNELS-1);
         credit       <= '0;
         mode_q       <= '0;
         refresh_cnt  <= '0;
         pending      <= 1'b0;
         error_status <= '0;
         wptr         <= '0;
         rptr         <= '0;
         queue_count  <= '0;
      end else begin
         mode_q <= arb_mode;
         if (xfer && arb_mode != 2'b01) ptr <= gnt_idx;
         // hold implies gnt_idx == ptr, so credit only grows while the same channel keeps its turn
         if (arb_mode != mode_q || arb_mode != 2'b10) credit <= '0;
         else if (xfer) credit <= hold ? credit + 1'b1 : WEIGHT_WIDTH'(1);
         if (enable && refresh_interval != '0) refresh_cnt <= deadline ? '0 : refresh_cnt + 32'd1;
         pending      <= (pending && !rpush) || deadline;
         error_status <= error_status | {deadline && pending && !rpush, arb_mode == 2'b11};
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         queue_count <= queue_count + QW'(push) - QW'(pop);
      end
   end
endmodule

// File: tb/tb_multi_channel_scheduler.sv
// tb_multi_channel_scheduler: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the scheduler.
module tb_multi_channel_scheduler;
   localparam int CH = 4, AW = 32, DW = 64, D = 8, WW = 4;
   localparam int EW = 1 + 1 + 2 + AW + DW;
   localparam logic [3:0] WEXP [8] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd4, 4'd8, 4'd8, 4'd1};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable;
   logic [1:0] arb_mode;
   logic [31:0] refresh_interval;
   logic [CH*WW-1:0] ch_weight;
   logic [3:0] queue_count;
   logic ready;
   logic [1:0] error_status;

   multi_channel_scheduler_if #(.CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   multi_channel_scheduler #(
      .CHANNELS(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(D), .WEIGHT_WIDTH(WW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .arb_mode(arb_mode),
      .refresh_interval(refresh_interval), .ch_weight_packed(ch_weight), .bus(bus),
      .queue_count(queue_count), .ready(ready), .error_status(error_status)
   );

   always #5 clk = ~clk;

   logic [EW-1:0] q [$];
   int m_last, m_cred;
   logic m_pend;
   logic [31:0] m_cnt;
   logic [1:0] m_err, m_prev;
   int n_tests = 0, n_fail = 0;
   logic [CH-1:0] obs_grant;
   logic obs_ref;
   logic [1:0] obs_ch;
   logic [3:0] obs_cnt;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_last = CH - 1;
      m_cred = 0;
      m_pend = 1'b0;
      m_cnt  = '0;
      m_err  = '0;
      m_prev = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic int lim(input int c);
      int w;
      w = int'(ch_weight[c*WW +: WW]);
      return w == 0 ? 1 : w;
   endfunction

   // channel granted this cycle under the spec's rules, -1 if none
   function automatic int pick();
      int s;
      if (!enable || q.size() == D || m_pend || arb_mode == 2'd3) return -1;
      if (arb_mode == 2'd1) s = 0;
      else if (arb_mode == 2'd2 && m_cred > 0 && m_cred < lim(m_last) && bus.ch_req_valid[m_last]) s = m_last;
      else s = (m_last + 1) % CH;
      for (int i = 0; i < CH; i++)
         if (bus.ch_req_valid[(s + i) % CH]) return (s + i) % CH;
      return -1;
   endfunction

   task automatic step();
      int g;
      logic [CH-1:0] eg;
      logic [EW-1:0] ent;
      logic rp, dl;
      @(negedge clk);
      g = pick();
      eg = g < 0 ? '0 : CH'(1) << g;
      ent = '0;
      if (g >= 0) ent = {1'b0, bus.ch_wr_en[g], 2'(g), bus.ch_addr_packed[g*AW +: AW], bus.ch_wdata_packed[g*DW +: DW]};
      check("grant", bus.ch_req_ready, eg);
      check("cmd_valid", bus.cmd_valid, q.size() != 0);
      if (q.size() != 0)
         check("head", {bus.cmd_refresh, bus.cmd_wr, bus.cmd_ch, bus.cmd_addr, bus.cmd_wdata}, q[0]);
      check("queue_count", queue_count, q.size());
      check("ready", ready, enable && q.size() == 0 && !m_pend);
      check("error_status", error_status, m_err);
      obs_grant = bus.ch_req_ready;
      obs_ref   = bus.cmd_valid && bus.cmd_refresh;
      obs_ch    = bus.cmd_ch;
      obs_cnt   = queue_count;
      @(posedge clk);
      rp = m_pend && q.size() < D;
      if (q.size() != 0 && bus.cmd_ready) void'(q.pop_front());
      if (g >= 0) q.push_back(ent);
      else if (rp) q.push_back({1'b1, {(EW-1){1'b0}}});
      dl = 1'b0;
      if (enable && refresh_interval != 0) begin
         if (m_cnt >= refresh_interval - 32'd1) begin
            m_cnt = '0;
            dl = 1'b1;
         end else m_cnt = m_cnt + 32'd1;
      end
      if (dl && m_pend && !rp) m_err[1] = 1'b1;
      m_pend = (m_pend && !rp) || dl;
      if (arb_mode == 2'd3) m_err[0] = 1'b1;
      if (arb_mode != m_prev || arb_mode != 2'd2) m_cred = 0;
      else if (g >= 0) m_cred = (g == m_last && m_cred > 0 && m_cred < lim(m_last)) ? m_cred + 1 : 1;
      if (g >= 0 && arb_mode != 2'd1) m_last = g;
      m_prev = arb_mode;
      #1;
   endtask

   task automatic rand_inputs();
      bus.ch_req_valid = CH'($urandom);
      bus.ch_wr_en     = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
         bus.ch_addr_packed[c*AW +: AW]  = $urandom;
         bus.ch_wdata_packed[c*DW +: DW] = {$urandom, $urandom};
      end
      bus.cmd_ready = $urandom_range(0, 9) < 7;
      enable        = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 29) == 0) arb_mode = 2'($urandom_range(0, 2));
   endtask

   initial begin
      int xfers, nref;
      enable = 1'b1;
      arb_mode = 2'd0;
      refresh_interval = '0;
      ch_weight = '0;
      bus.ch_req_valid = '0;
      bus.ch_wr_en = '0;
      bus.ch_addr_packed = '0;
      bus.ch_wdata_packed = '0;
      bus.cmd_ready = 1'b1;
      do_reset();
      step();
      check("rst_count", obs_cnt, 0);

      bus.ch_req_valid = '1;
      bus.ch_wr_en = 4'b0101;
      for (int c = 0; c < CH; c++) bus.ch_addr_packed[c*AW +: AW] = 32'h100 * (c + 1);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step();
         check("rr_order", obs_grant, 4'b0001 << (i % 4));
         if (i > 0) check("rr_cmd_ch", obs_ch, (i - 1) % 4);
      end

      arb_mode = 2'd1;
      bus.ch_req_valid = 4'b1010;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         check("fixed_ch1", obs_grant, 4'b0010);
      end

      arb_mode = 2'd2;
      ch_weight = {4'd2, 4'd0, 4'd3, 4'd1};
      bus.ch_req_valid = '0;
      do_reset();
      step();
      bus.ch_req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("wrr_order", obs_grant, WEXP[i]);
      end

      arb_mode = 2'd0;
      bus.cmd_ready = 1'b0;
      bus.ch_req_valid = 4'b0001;
      do_reset();
      xfers = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (obs_grant != '0) xfers++;
      end
      check("full_xfers", xfers, 8);
      check("full_count", queue_count, 8);
      check("full_block", obs_grant, 0);
      bus.cmd_ready = 1'b1;
      step();
      check("full_pop_block", obs_grant, 0);
      bus.cmd_ready = 1'b0;
      step();
      check("pop_count", obs_cnt, 7);
      check("grant_resume", obs_grant, 4'b0001);

      bus.ch_req_valid = '0;
      bus.cmd_ready = 1'b1;
      refresh_interval = 32'd5;
      do_reset();
      nref = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (obs_ref) nref++;
      end
      check("refresh_every5", nref, 4);
      bus.cmd_ready = 1'b0;
      bus.ch_req_valid = 4'b0001;
      repeat (30) step();
      check("refresh_overdue", error_status, 2'b10);

      refresh_interval = '0;
      arb_mode = 2'd3;
      bus.ch_req_valid = '1;
      bus.cmd_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         check("mode3_grant", obs_grant, 0);
      end
      check("mode3_err", error_status, 2'b01);

      arb_mode = 2'd0;
      bus.cmd_ready = 1'b0;
      do_reset();
      repeat (4) step();
      check("burst_count", queue_count, 4);
      #2 rst_n = 1'b0;
      #1;
      check("async_count", queue_count, 0);
      check("async_valid", bus.cmd_valid, 0);

      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < CH; c++) ch_weight[c*WW +: WW] = WW'($urandom_range(0, 5));
         refresh_interval = $urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(1, 24));
         arb_mode = 2'($urandom_range(0, 2));
         do_reset();
         for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
